// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, default widths and the
// EX/MEM payload layout used wherever the default widths apply.
package mips_pkg;

    localparam int CTRL_W         = 4;
    localparam int CTRL_MEMREAD   = 3;
    localparam int CTRL_MEMTOREG  = 2;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_REGWRITE  = 0;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]     alu_out;
        logic [DATA_W_DEF-1:0]     store_data;
        logic [REG_ADDR_W_DEF-1:0] reg_addr;
        logic [CTRL_W-1:0]         ctrl;
    } ex_mem_t;

    // Drops RegWrite for an instruction whose destination is $zero.
    function automatic logic [CTRL_W-1:0] squash_r0(input logic [CTRL_W-1:0] ctrl,
                                                    input logic              to_r0);
        logic [CTRL_W-1:0] res;
        res = ctrl;
        if (to_r0) res[CTRL_REGWRITE] = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush. Main entry drives
// the output; the skid entry catches the one beat accepted while the consumer stalls.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    // Encoding is {main_v, skid_v}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_e;

    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept_in, accept_out;

    assign out_valid_o = state_q[1];
    assign in_ready_o  = ready_q;
    assign out_data_o  = main_q;
    assign accept_in   = in_valid_i & ready_q;
    assign accept_out  = state_q[1] & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept_in) begin
                        state_d = S_ONE;
                        main_d  = in_data_i;
                    end
                end
                S_ONE: begin
                    if (accept_in && accept_out) begin
                        main_d = in_data_i;
                    end else if (accept_in) begin
                        state_d = S_TWO;
                        skid_d  = in_data_i;
                    end else if (accept_out) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (accept_out) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with back-pressure: packs the EX payload into a skid
// buffer, drops $zero writes at capture and zeroes control while no entry is held.
module ex_mem_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SQUASH_R0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_alu_out,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_reg_addr,
    input  logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_alu_out,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_reg_addr,
    output logic [CTRL_W-1:0]     mem_ctrl
);

    localparam int PW = 2 * DATA_W + REG_ADDR_W + CTRL_W;

    logic [CTRL_W-1:0] cap_ctrl;
    logic [CTRL_W-1:0] held_ctrl;
    logic [PW-1:0]     in_pl;
    logic [PW-1:0]     out_pl;

    assign cap_ctrl = squash_r0(ex_ctrl, SQUASH_R0 && (ex_reg_addr == '0));
    assign in_pl    = {ex_alu_out, ex_store_data, ex_reg_addr, cap_ctrl};

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (ex_valid),
        .in_ready_o  (ex_ready),
        .in_data_i   (in_pl),
        .out_valid_o (mem_valid),
        .out_ready_i (mem_ready),
        .out_data_o  (out_pl)
    );

    assign {mem_alu_out, mem_store_data, mem_reg_addr, held_ctrl} = out_pl;
    // Stale control after a flush must never reach MEM/WB as a live write.
    assign mem_ctrl = mem_valid ? held_ctrl : '0;

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX→MEM pipeline stage for the MIPS core; successor to the fixed-width EX/MEM latch.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush and bubble insertion.
- Optionally squashes writes to register 0.
- Sits between the ALU stage and data-memory stage. Lets MEM stall back-pressure into EX without losing an in-flight instruction.

Parameters:
- DATA_W, 32, width of ALU result and store-data fields.
- REG_ADDR_W, 5, width of destination register address.
- SQUASH_R0, 1, when 1 an entry with RegWrite=1 and dest addr 0 is captured with RegWrite=0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill all held entries and the current input
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept (registered)
- ex_alu_out  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  rt read data for stores
- ex_reg_addr  in  REG_ADDR_W  destination register
- ex_ctrl  in  4  {MemRead, MemtoReg, MemWrite, RegWrite}, MSB first
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes the entry this cycle
- mem_alu_out  out  DATA_W  held ALU result
- mem_store_data  out  DATA_W  held store data
- mem_reg_addr  out  REG_ADDR_W  held destination
- mem_ctrl  out  4  held control; forced 4'b0 whenever mem_valid=0

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-low (rst_n); sampled only on the rising edge of clk.
- Reset values: mem_valid=0, mem_ctrl=0, mem_alu_out=0, mem_store_data=0, mem_reg_addr=0, skid entry empty. ex_ready=1 from the first edge after rst_n rises; ex_ready=0 while rst_n=0.
- Storage: main entry drives the mem_* ports; skid entry holds one extra instruction.
- State is encoded by {main_v, skid_v}: EMPTY (0,0), ONE (1,0), TWO (1,1). (0,1) is illegal.
- ex_ready = !skid_v (registered).
- Definitions: accept_in = ex_valid & ex_ready; accept_out = mem_valid & mem_ready.
- EMPTY:
  - accept_in → ONE, input loaded into main.
  - Otherwise stay in EMPTY.
- ONE:
  - accept_in & accept_out → ONE, main replaced by input.
  - accept_in & !accept_out → TWO, input loaded into skid.
  - !accept_in & accept_out → EMPTY.
  - Otherwise hold.
- TWO:
  - accept_out → ONE, skid moved to main.
  - Otherwise hold.
  - Input is ignored (ex_ready=0).
- Latency: one cycle from accept_in to mem_valid when empty. Order is strictly FIFO. No entry is lost or duplicated.
- Flush:
  - Next state EMPTY; mem_ctrl=0; ex_ready=1.
  - The input presented in the flush cycle is dropped.
  - Flush takes priority over accept_in and accept_out.
  - Data fields may retain stale values.
- Reset beats flush; reset mid-transfer discards everything.
- SQUASH_R0 is applied at capture time (into main or skid), not at output.
- Bubble: mem_ctrl is zero whenever mem_valid=0, so MEM/WB never sees a stray MemWrite or RegWrite.
- Data fields update only on load. When idle they hold their value, for low toggle and easy waveform reading.
- All field widths pass through unchanged; there is no arithmetic.

Decomposition:
- Shared package, mips_pkg:
  - Control-bit index constants CTRL_MEMREAD=3, CTRL_MEMTOREG=2, CTRL_MEMWRITE=1, CTRL_REGWRITE=0.
  - CTRL_W=4.
  - Packed struct type for the stage payload (alu_out, store_data, reg_addr, ctrl), sized by the defaults.
- One natural sub-module: pipe_skid_buf, generic over payload width, implementing the EMPTY/ONE/TWO handshake and flush.
- ex_mem_pipe wraps pipe_skid_buf, packing/unpacking the payload and applying SQUASH_R0 and ctrl gating.

Test Plan:
1. Reset and flow-through:
   - rst_n=0 for 2 cycles, then mem_ready=1 and ex_valid=1 for 3 cycles with alu_out=0x10, 0x20, 0x30.
   - Required: mem_valid=0 and mem_ctrl=0 during reset. Outputs 0x10, 0x20, 0x30 on consecutive cycles, each one cycle after its input. ex_ready stays 1.
2. Back-pressure into skid:
   - mem_ready=0, push A=0x100 then B=0x200.
   - Required: ex_ready drops to 0 after B. Push C=0x300 while ex_ready=0 is ignored. Releasing mem_ready yields A then B; C never appears.
3. Flush mid-stall:
   - Reach state TWO (entries A and B), then assert flush with ex_valid=1 carrying D.
   - Required: next cycle mem_valid=0, mem_ctrl=0, ex_ready=1. A, B and D are never output.
4. Simultaneous accept in ONE:
   - Hold entry A, mem_ready=1, ex_valid=1 with E=0x55.
   - Required: next cycle mem_alu_out=0x55, mem_valid=1, state stays ONE.
5. R0 squash:
   - Input reg_addr=0, ctrl=4'b0001.
   - Required: mem_ctrl=4'b0000 with mem_valid=1 when SQUASH_R0=1; mem_ctrl=4'b0001 when SQUASH_R0=0.
6. Reset mid-operation:
   - Reach state TWO, then rst_n=0 for one cycle.
   - Required: next cycle mem_valid=0, all data outputs 0; after release, ex_ready=1.
